// File: rtl/maquina_maluca_lote_pkg.sv
// Shared state codes and helpers for the batch coffee sequencer.
// Also used by the original single-brew controller and the bench.
package maquina_maluca_pkg;

  typedef enum logic [3:0] {
    IDLE                = 4'd1,
    LIGAR_MAQUINA       = 4'd2,
    VERIFICAR_AGUA      = 4'd3,
    ENCHER_RESERVATORIO = 4'd4,
    MOER_CAFE           = 4'd5,
    COLOCAR_NO_FILTRO   = 4'd6,
    PASSAR_AGITADOR     = 4'd7,
    TAMPEAR             = 4'd8,
    REALIZAR_EXTRACAO   = 4'd9
  } estado_t;

  function automatic int timer_w(int g, int e);
    int m;
    m = (g > e) ? g : e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/maquina_maluca_lote_if.sv
// Request/status bundle of the batch sequencer.
// master: start, cups, abort out; status in. slave: the reverse.
interface maquina_maluca_lote_if #(
  parameter int CUPS_W  = 3,
  parameter int WATER_W = 4
);
  logic               start;
  logic [CUPS_W-1:0]  cups;
  logic               abort;
  logic [3:0]         state;
  logic               busy;
  logic               done;
  logic [WATER_W-1:0] water_level;
  logic [CUPS_W-1:0]  cups_left;

  modport master (
    output start, cups, abort,
    input  state, busy, done, water_level, cups_left
  );

  modport slave (
    input  start, cups, abort,
    output state, busy, done, water_level, cups_left
  );
endinterface

// File: rtl/maquina_maluca_lote_contador_etapa.sv
// Loadable down-counter for the grind and extraction stages.
// Ports: clk, rst, load, load_val in; tc out (count is zero).
module contador_etapa #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/maquina_maluca_lote.sv
// Batch coffee sequencer: brews 1..MAX_CUPS cups per start.
// Ports: clk, rst; bus (slave) carries request and status.
module maquina_maluca_lote
  import maquina_maluca_pkg::*;
#(
  parameter int MAX_CUPS       = 4,
  parameter int CUPS_W         = 3,
  parameter int TANK_CAP       = 8,
  parameter int WATER_W        = 4,
  parameter int FILL_RATE      = 2,
  parameter int CUP_COST       = 2,
  parameter int GRIND_CYCLES   = 3,
  parameter int EXTRACT_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  maquina_maluca_lote_if.slave bus
);
  localparam int TW = timer_w(GRIND_CYCLES, EXTRACT_CYCLES);

  estado_t            st;
  estado_t            nxt;
  logic [WATER_W-1:0] wl;
  logic [CUPS_W-1:0]  cl;
  logic               dn;
  logic               tc;
  logic               ld;
  logic [TW-1:0]      ld_val;
  logic [WATER_W:0]   fill_sum;
  logic               req_ok;
  logic               kill;

  assign fill_sum = {1'b0, wl} + (WATER_W+1)'(FILL_RATE);
  assign req_ok   = bus.start && (bus.cups != '0) &&
                    (bus.cups <= CUPS_W'(MAX_CUPS));
  assign kill     = bus.abort && (st != IDLE);

  always_comb begin
    nxt = st;
    if (kill) begin
      nxt = IDLE;
    end else begin
      unique case (st)
        IDLE:
          if (req_ok) nxt = LIGAR_MAQUINA;
        LIGAR_MAQUINA:
          nxt = VERIFICAR_AGUA;
        VERIFICAR_AGUA:
          nxt = (wl >= WATER_W'(CUP_COST)) ?
                MOER_CAFE : ENCHER_RESERVATORIO;
        ENCHER_RESERVATORIO:
          if (wl >= WATER_W'(TANK_CAP)) nxt = VERIFICAR_AGUA;
        MOER_CAFE:
          if (tc) nxt = COLOCAR_NO_FILTRO;
        COLOCAR_NO_FILTRO:
          nxt = PASSAR_AGITADOR;
        PASSAR_AGITADOR:
          nxt = TAMPEAR;
        TAMPEAR:
          nxt = REALIZAR_EXTRACAO;
        REALIZAR_EXTRACAO:
          if (tc)
            nxt = (cl == CUPS_W'(1)) ? IDLE : VERIFICAR_AGUA;
        default:
          nxt = IDLE;
      endcase
    end
  end

  // Timer is reloaded on every state change: with the stage
  // length for timed stages, with zero everywhere else.
  always_comb begin
    ld     = (nxt != st);
    ld_val = '0;
    if (nxt == MOER_CAFE)
      ld_val = TW'(GRIND_CYCLES - 1);
    else if (nxt == REALIZAR_EXTRACAO)
      ld_val = TW'(EXTRACT_CYCLES - 1);
  end

  contador_etapa #(.W(TW)) u_etapa (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      wl <= '0;
      cl <= '0;
      dn <= 1'b0;
    end else begin
      st <= nxt;
      dn <= 1'b0;
      if (kill) begin
        cl <= '0;
      end else begin
        case (st)
          IDLE:
            if (req_ok) cl <= bus.cups;
          ENCHER_RESERVATORIO:
            if (wl < WATER_W'(TANK_CAP))
              wl <= (fill_sum > (WATER_W+1)'(TANK_CAP)) ?
                    WATER_W'(TANK_CAP) : fill_sum[WATER_W-1:0];
          REALIZAR_EXTRACAO:
            if (tc) begin
              wl <= wl - WATER_W'(CUP_COST);
              cl <= cl - 1'b1;
              dn <= (cl == CUPS_W'(1));
            end
          default: ;
        endcase
      end
    end
  end

  assign bus.state       = st;
  assign bus.busy        = (st != IDLE);
  assign bus.done        = dn;
  assign bus.water_level = wl;
  assign bus.cups_left   = cl;
endmodule

// File: tb/tb_maquina_maluca_lote.sv
// Bench for the batch coffee sequencer.
// Expected per-cycle trace is built from the brewing rules.
module tb_maquina_maluca_lote;
  localparam int CAP  = 8;
  localparam int FILL = 2;
  localparam int COST = 2;
  localparam int G    = 3;
  localparam int E    = 4;
  localparam int MAXC = 4;

  typedef struct {
    int st;
    int wl;
    int cl;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   mdl_level = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  maquina_maluca_lote_if #(.CUPS_W(3), .WATER_W(4)) bus ();

  maquina_maluca_lote dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // One entry per cycle, starting with the first LIGAR cycle.
  function automatic void build(int n, int lvl0);
    int lvl;
    int left;
    int k;
    lvl  = lvl0;
    left = n;
    q.delete();
    q.push_back('{2, lvl, left});
    for (int c = 0; c < n; c++) begin
      q.push_back('{3, lvl, left});
      if (lvl < COST) begin
        k = (CAP - lvl + FILL - 1) / FILL + 1;
        for (int i = 0; i < k; i++)
          q.push_back('{4, imin(lvl + i * FILL, CAP), left});
        lvl = CAP;
        q.push_back('{3, lvl, left});
      end
      for (int i = 0; i < G; i++) q.push_back('{5, lvl, left});
      q.push_back('{6, lvl, left});
      q.push_back('{7, lvl, left});
      q.push_back('{8, lvl, left});
      for (int i = 0; i < E; i++) q.push_back('{9, lvl, left});
      lvl  -= COST;
      left -= 1;
    end
    q.push_back('{1, lvl, 0});
  endfunction

  // cut >= 0: abort (or reset if use_rst) during entry cut.
  task automatic run_batch(int n, int cut, bit use_rst);
    int last;
    bus.start = 1'b1;
    bus.cups  = 3'(n);
    tick();
    bus.start = 1'b0;
    bus.cups  = '0;
    build(n, mdl_level);
    last = q.size() - 1;
    for (int k = 0; k <= last; k++) begin
      chk("state", bus.state, q[k].st);
      chk("water", bus.water_level, q[k].wl);
      chk("cups_left", bus.cups_left, q[k].cl);
      chk("busy", bus.busy, (k != last));
      chk("done", bus.done, (k == last));
      if (k == cut) begin
        if (use_rst) begin
          rst = 1'b1;
          #1;
          chk("rst_state", bus.state, 1);
          chk("rst_water", bus.water_level, 0);
          chk("rst_cups", bus.cups_left, 0);
          chk("rst_done", bus.done, 0);
          rst = 1'b0;
          mdl_level = 0;
          tick();
        end else begin
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
          chk("abort_state", bus.state, 1);
          chk("abort_cups", bus.cups_left, 0);
          chk("abort_water", bus.water_level, q[k].wl);
          chk("abort_done", bus.done, 0);
          mdl_level = q[k].wl;
        end
        return;
      end
      if (k < last) tick();
    end
    mdl_level = q[last].wl;
  endtask

  task automatic bad_req(int n);
    bus.start = 1'b1;
    bus.cups  = 3'(n);
    tick();
    bus.start = 1'b0;
    bus.cups  = '0;
    chk("bad_state", bus.state, 1);
    chk("bad_water", bus.water_level, mdl_level);
    chk("bad_cups", bus.cups_left, 0);
    chk("bad_done", bus.done, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("reset_state", bus.state, 1);
    chk("reset_water", bus.water_level, 0);
    chk("reset_busy", bus.busy, 0);
    rst = 1'b0;
    mdl_level = 0;
    tick();
  endtask

  initial begin
    int n;
    int cut;
    bus.start = 1'b0;
    bus.cups  = '0;
    bus.abort = 1'b0;
    tick();
    do_reset();

    run_batch(1, -1, 0);
    chk("lvl_after_1", bus.water_level, 6);
    run_batch(2, -1, 0);
    chk("lvl_after_2", bus.water_level, 2);

    do_reset();
    run_batch(4, -1, 0);
    chk("lvl_after_4", bus.water_level, 0);
    run_batch(1, -1, 0);

    bad_req(0);
    bad_req(5);
    bad_req(7);

    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort_state", bus.state, 1);
    chk("idle_abort_water", bus.water_level, mdl_level);

    build(2, mdl_level);
    cut = -1;
    for (int k = 0; k < q.size(); k++)
      if (cut < 0 && q[k].st == 9) cut = k + 1;
    run_batch(2, cut, 0);

    do_reset();
    run_batch(1, 4, 1);
    run_batch(1, -1, 0);

    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(0, 7);
      if (n == 0 || n > MAXC) begin
        bad_req(n);
      end else begin
        build(n, mdl_level);
        cut = -1;
        if ($urandom_range(0, 3) == 0)
          cut = $urandom_range(0, q.size() - 2);
        run_batch(n, cut, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/maquina_maluca_lote.md
Name: maquina_maluca_lote

Overview:
- Parametrised successor of the single-brew coffee-machine FSM. Brews a batch of 1..MAX_CUPS cups per start.
- Models a finite water tank with a real level counter, multi-cycle grind and extraction stages, and an abort path.
- Sits beside the original controller as the top-level sequencer. The state code is exported for display and for the bench.

Parameters:
- MAX_CUPS, 4, largest batch accepted; cups request above this is rejected.
- CUPS_W, 3, width of the cups and cups_left ports; must hold MAX_CUPS.
- TANK_CAP, 8, tank capacity in water units.
- WATER_W, 4, width of water_level; must hold TANK_CAP.
- FILL_RATE, 2, units added per cycle in ENCHER_RESERVATORIO; must be at least 1.
- CUP_COST, 2, units consumed per cup; must satisfy 1 <= CUP_COST <= TANK_CAP.
- GRIND_CYCLES, 3, cycles spent in MOER_CAFE; must be at least 1.
- EXTRACT_CYCLES, 4, cycles spent in REALIZAR_EXTRACAO; must be at least 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level-sampled request; acted on only in IDLE.
- cups  in  CUPS_W  batch size, sampled together with start.
- abort  in  1  cancel the current batch; highest priority.
- state  out  4  registered current state code.
- busy  out  1  high whenever state != IDLE (combinational from the state register).
- done  out  1  registered one-cycle pulse when a batch completes normally.
- water_level  out  WATER_W  registered tank level.
- cups_left  out  CUPS_W  registered count of cups still to brew.

Behaviour:
- State codes: IDLE=1, LIGAR_MAQUINA=2, VERIFICAR_AGUA=3, ENCHER_RESERVATORIO=4, MOER_CAFE=5, COLOCAR_NO_FILTRO=6, PASSAR_AGITADOR=7, TAMPEAR=8, REALIZAR_EXTRACAO=9. Any other code goes to IDLE on the next edge.
- Reset (asynchronous, any time, including mid-batch) sets: state=IDLE, water_level=0, cups_left=0, done=0, stage timer=0.
- IDLE:
  - start=1 with 1<=cups<=MAX_CUPS: go to LIGAR_MAQUINA and load cups_left=cups.
  - cups=0 or cups>MAX_CUPS: stay in IDLE, no change to any register.
- LIGAR_MAQUINA: always goes to VERIFICAR_AGUA after 1 cycle.
- VERIFICAR_AGUA (1 cycle):
  - water_level >= CUP_COST: go to MOER_CAFE.
  - otherwise: go to ENCHER_RESERVATORIO.
- ENCHER_RESERVATORIO:
  - While water_level < TANK_CAP: each cycle water_level <= min(water_level+FILL_RATE, TANK_CAP), state holds.
  - Once water_level == TANK_CAP: go to VERIFICAR_AGUA.
  - Occupancy = ceil((TANK_CAP-L)/FILL_RATE)+1 cycles, where L is the level on entry.
- MOER_CAFE: stays exactly GRIND_CYCLES cycles using the stage timer, then goes to COLOCAR_NO_FILTRO.
- COLOCAR_NO_FILTRO, PASSAR_AGITADOR, TAMPEAR: 1 cycle each, in that order, then REALIZAR_EXTRACAO.
- REALIZAR_EXTRACAO: stays exactly EXTRACT_CYCLES cycles. On its last cycle:
  - water_level -= CUP_COST and cups_left -= 1.
  - If the decremented cups_left != 0: go to VERIFICAR_AGUA.
  - Otherwise: go to IDLE and set done=1 for exactly that first IDLE cycle.
- Stage timer: width clog2(max(GRIND_CYCLES,EXTRACT_CYCLES))+1. Cleared on every state change.
- abort=1 in any state other than IDLE:
  - Next state is IDLE; cups_left=0; timer cleared; done stays 0.
  - water_level keeps its current value, including a partial fill.
  - abort wins over every other transition and over the extraction decrement on the same edge.
- abort in IDLE has no effect. start and cups are ignored outside IDLE.
- water_level never underflows, because VERIFICAR_AGUA guarantees level >= CUP_COST before each cup. It never exceeds TANK_CAP (saturating add).

Decomposition:
- Package maquina_maluca_pkg: the state code constants (shared with the original controller and the bench) and a helper for the timer width.
- Sub-module contador_etapa: loadable down-counter with a terminal-count flag, reused for both the grind and extraction stages.

Test Plan:
- Reset, then start=1, cups=1: state sequence 2,3,4x5,3,5x3,6,7,8,9x4,1. done pulses on the first IDLE cycle; water_level ends at 6; busy low on the same cycle as done.
- From water_level=6, start with cups=2: first VERIFICAR_AGUA goes straight to MOER_CAFE (no fill); after cup 1 water_level=4 and the FSM returns to state 3; ends at water_level=2 with cups_left=0 and one done pulse.
- From reset, cups=4: exactly one fill; water_level goes 8,6,4,2,0 across the cups. A following start with cups=1 refills, ENCHER occupying 5 cycles.
- cups=0 and cups=5 with start=1: state stays at 1; cups_left, water_level and done unchanged.
- abort=1 on the second cycle of REALIZAR_EXTRACAO with cups=2 requested: next state is 1, cups_left=0, no done pulse, water_level unchanged.
- rst asserted mid-ENCHER (water_level=4): outputs clear immediately without waiting for a clk edge; start is honoured again once rst is released.
